uart_rx_parity: RTL and testbench
=================================

// Module: uart_rx_parity
// PURPOSE
//  UART receiver for 8E1 frames: start(0), 8 data bits LSB first, even parity, stop(1).
//  Pairs with the team's even-parity UART transmitter on the far end of the serial link.
//  Oversamples the line with a per-bit clock counter and samples each bit mid-cell.
//  Presents each received byte with a one-cycle valid pulse and error flags.
// PARAMETERS
//  CLKS_PER_BIT  434  i_Clock cycles per bit cell (>=4); counter width = $clog2(CLKS_PER_BIT)
// PORTS
//  i_Clock           in   1  system clock, all logic on posedge
//  i_Reset           in   1  reset, synchronous, active-high
//  i_Rx_Serial       in   1  asynchronous serial line, idle high
//  o_Rx_DV           out  1  one-cycle pulse: o_Rx_Byte and flags valid
//  o_Rx_Byte         out  8  last received data byte, held until next DV
//  o_Rx_Parity_Err   out  1  1 = parity mismatch on the frame flagged by o_Rx_DV
//  o_Rx_Active       out  1  high from start-bit detect until return to IDLE
//  o_Rx_Frame_Err    out  1  only with UART_RX_FRAME_ERR_EN; see CONFIGURATION
// BEHAVIOUR
//  Reset (i_Reset=1 at posedge): state=IDLE, counters=0, o_Rx_DV=0, o_Rx_Byte=8'h00,
//   o_Rx_Parity_Err=0, o_Rx_Active=0, o_Rx_Frame_Err=0, sync flops=1. Applies mid-frame,
//   abandons the partial frame, and produces no DV.
//  i_Rx_Serial passes through a 2-FF synchronizer (reset to 1); FSM sees the synced bit only.
//  FSM states: IDLE, START, DATA, PARITY, STOP, CLEANUP.
//   IDLE: count=0, bit index=0; synced line=0 -> START, o_Rx_Active<=1.
//   START: count to (CLKS_PER_BIT-1)/2; sample there: 0 -> count=0, go DATA;
//    1 -> glitch/false start, go IDLE, o_Rx_Active<=0, no DV.
//   DATA: after CLKS_PER_BIT-1 more clocks sample into bit[index]; index 0..7, then PARITY.
//   PARITY: after CLKS_PER_BIT-1 clocks sample p; error = p ^ (^byte) (even parity).
//   STOP: after CLKS_PER_BIT-1 clocks sample stop; go CLEANUP.
//   CLEANUP: 1 cycle; o_Rx_DV=1, o_Rx_Byte/o_Rx_Parity_Err update same cycle;
//    o_Rx_Active<=0; then IDLE.
//  Latency: DV is 1 cycle after the stop mid-sample, about 10.5 bit cells + 3 clocks after
//   the start falling edge.
//  The byte is delivered even when parity fails, with the flag set. No internal buffering:
//   the consumer must take the byte on the DV cycle, and the next frame overwrites it.
//  Back-to-back frames: a start edge immediately after CLEANUP is accepted (no idle gap needed).
//  Undefined state encodings -> IDLE.
// CONFIGURATION
//  UART_RX_FRAME_ERR_EN defined: adds o_Rx_Frame_Err, pulsed with o_Rx_DV when the stop
//   sample=0. The FSM then enters a BREAK wait and does not re-arm until the synced line
//   has been 1 for one full bit cell.
//  Undefined: port absent, stop sample ignored, DV pulses normally, no BREAK state.
// STRUCTURE
//  uart_pkg: state encodings (shared with the transmitter), default CLKS_PER_BIT, FRAME_BITS=11.
//  Sub-module uart_rx_sync: 2-FF synchronizer, sync reset to 1; instantiated once.
//  The parity XOR-reduce and the counters stay inline.
// TESTING (CLKS_PER_BIT=16 for the bench; also loopback with the team transmitter)
//  1. Frame 0xA5 with parity 0 -> DV pulses once, byte=0xA5, Parity_Err=0, Active low after.
//  2. Frame 0x07 with parity 0 (wrong) -> DV, byte=0x07, Parity_Err=1.
//  3. Low glitch of 4 clocks on an idle line -> no DV, Active returns to 0, FSM in IDLE.
//  4. Back-to-back 0x00, 0xFF with no idle gap -> two DVs, correct bytes, both Parity_Err=0.
//  5. i_Reset asserted mid-data for 1 cycle -> outputs at reset values, no DV; next frame 0x3C OK.
//  6. FRAME_ERR_EN: stop=0, line held low 3 cells -> DV with Frame_Err=1; no new DV until
//     the line has been high 1 cell; next frame 0x55 decodes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, default bit timing, frame length.
// Used by both the receiver and the even-parity transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_CLEANUP = 3'd5,
    S_BREAK   = 3'd6
  } uart_state_e;

  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int FRAME_BITS       = 11;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle (1).
module uart_rx_sync (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Sync
);

  logic meta;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      meta   <= 1'b1;
      o_Sync <= 1'b1;
    end else begin
      meta   <= i_Async;
      o_Sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_parity.sv
// 8E1 UART receiver with mid-cell sampling, parity flag and one-cycle DV pulse.
// Optional UART_RX_FRAME_ERR_EN adds o_Rx_Frame_Err and a BREAK wait after a bad stop.
module uart_rx_parity #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEF
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Parity_Err,
  output logic       o_Rx_Active
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       o_Rx_Frame_Err
`endif
);

  import uart_pkg::*;

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic             par_err;
  logic             rx_sync;
`ifdef UART_RX_FRAME_ERR_EN
  logic             brk_pend;
`endif

  uart_rx_sync u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Async (i_Rx_Serial),
    .o_Sync  (rx_sync)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state           <= S_IDLE;
      clk_cnt         <= '0;
      bit_idx         <= '0;
      rx_shift        <= '0;
      par_err         <= 1'b0;
      o_Rx_DV         <= 1'b0;
      o_Rx_Byte       <= 8'h00;
      o_Rx_Parity_Err <= 1'b0;
      o_Rx_Active     <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      o_Rx_Frame_Err  <= 1'b0;
      brk_pend        <= 1'b0;
`endif
    end else begin
      o_Rx_DV <= 1'b0;
      case (state)
        S_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_sync) begin
            state       <= S_START;
            o_Rx_Active <= 1'b1;
          end
        end
        // A start bit that has gone high again by mid-cell is a glitch.
        S_START: begin
          if (clk_cnt == CNT_HALF) begin
            clk_cnt <= '0;
            if (!rx_sync) begin
              state <= S_DATA;
            end else begin
              state       <= S_IDLE;
              o_Rx_Active <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (clk_cnt != CNT_LAST) begin
            clk_cnt <= clk_cnt + 1'b1;
          end else begin
            clk_cnt           <= '0;
            rx_shift[bit_idx] <= rx_sync;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= S_PARITY;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (clk_cnt != CNT_LAST) begin
            clk_cnt <= clk_cnt + 1'b1;
          end else begin
            clk_cnt <= '0;
            par_err <= rx_sync ^ (^rx_shift);
            state   <= S_STOP;
          end
        end
        // Outputs are loaded here so they are valid during the CLEANUP cycle.
        S_STOP: begin
          if (clk_cnt != CNT_LAST) begin
            clk_cnt <= clk_cnt + 1'b1;
          end else begin
            clk_cnt         <= '0;
            o_Rx_DV         <= 1'b1;
            o_Rx_Byte       <= rx_shift;
            o_Rx_Parity_Err <= par_err;
`ifdef UART_RX_FRAME_ERR_EN
            o_Rx_Frame_Err  <= ~rx_sync;
            brk_pend        <= ~rx_sync;
`endif
            state           <= S_CLEANUP;
          end
        end
        S_CLEANUP: begin
          clk_cnt     <= '0;
          o_Rx_Active <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
          o_Rx_Frame_Err <= 1'b0;
          state          <= brk_pend ? S_BREAK : S_IDLE;
`else
          state          <= S_IDLE;
`endif
        end
`ifdef UART_RX_FRAME_ERR_EN
        // Re-arm only after one uninterrupted high bit cell.
        S_BREAK: begin
          if (!rx_sync) begin
            clk_cnt <= '0;
          end else if (clk_cnt == CNT_LAST) begin
            clk_cnt  <= '0;
            brk_pend <= 1'b0;
            state    <= S_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        default: begin
          state       <= S_IDLE;
          clk_cnt     <= '0;
          bit_idx     <= '0;
          o_Rx_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed bench for uart_rx_parity at 16 clocks per bit.
module tb_uart_rx_parity;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       dv;
  logic [7:0] rx_byte;
  logic       perr;
  logic       active;
`ifdef UART_RX_FRAME_ERR_EN
  logic       ferr;
`endif

  int checks = 0;
  int errors = 0;

  int         dv_cnt = 0;
  logic [7:0] last_byte = 8'h00, prev_byte = 8'h00;
  logic       last_perr = 1'b0, prev_perr = 1'b0;
  logic       last_ferr = 1'b0;
  logic       active_seen = 1'b0;

  always #5 clk = ~clk;

  uart_rx_parity #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock         (clk),
    .i_Reset         (rst),
    .i_Rx_Serial     (rx),
    .o_Rx_DV         (dv),
    .o_Rx_Byte       (rx_byte),
    .o_Rx_Parity_Err (perr),
    .o_Rx_Active     (active)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .o_Rx_Frame_Err  (ferr)
`endif
  );

  // Capture every DV cycle away from the active edge.
  always @(negedge clk) begin
    if (active) active_seen = 1'b1;
    if (dv === 1'b1) begin
      dv_cnt    = dv_cnt + 1;
      prev_byte = last_byte;
      prev_perr = last_perr;
      last_byte = rx_byte;
      last_perr = perr;
`ifdef UART_RX_FRAME_ERR_EN
      last_ferr = ferr;
`endif
    end
  end

  task automatic cells(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
    rx = 1'b0;
    cells(1);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cells(1);
    end
    rx = p;
    cells(1);
    rx = s;
    cells(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (dv !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", dv); end
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte got %h want 00", rx_byte); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", perr); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", active); end
`ifdef UART_RX_FRAME_ERR_EN
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", ferr); end
`endif
    rst = 1'b0;
    cells(1);
  endtask

  task automatic test_good_frame();
    int n0;
    n0 = dv_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    cells(1);
    checks++; if (dv_cnt - n0 !== 1) begin errors++; $display("FAIL a5_dv_count got %0d want 1", dv_cnt - n0); end
    checks++; if (last_byte !== 8'hA5) begin errors++; $display("FAIL a5_byte got %h want a5", last_byte); end
    checks++; if (last_perr !== 1'b0) begin errors++; $display("FAIL a5_perr got %b want 0", last_perr); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL a5_active got %b want 0", active); end
    checks++; if (rx_byte !== 8'hA5) begin errors++; $display("FAIL a5_byte_held got %h want a5", rx_byte); end
`ifdef UART_RX_FRAME_ERR_EN
    checks++; if (last_ferr !== 1'b0) begin errors++; $display("FAIL a5_ferr got %b want 0", last_ferr); end
`endif
  endtask

  task automatic test_parity_err();
    int n0;
    n0 = dv_cnt;
    send_frame(8'h07, 1'b0, 1'b1);
    cells(1);
    checks++; if (dv_cnt - n0 !== 1) begin errors++; $display("FAIL p07_dv_count got %0d want 1", dv_cnt - n0); end
    checks++; if (last_byte !== 8'h07) begin errors++; $display("FAIL p07_byte got %h want 07", last_byte); end
    checks++; if (last_perr !== 1'b1) begin errors++; $display("FAIL p07_perr got %b want 1", last_perr); end
  endtask

  task automatic test_glitch();
    int n0;
    n0 = dv_cnt;
    active_seen = 1'b0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    cells(3);
    checks++; if (active_seen !== 1'b1) begin errors++; $display("FAIL glitch_active_seen got %b want 1", active_seen); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL glitch_active got %b want 0", active); end
    checks++; if (dv_cnt - n0 !== 0) begin errors++; $display("FAIL glitch_dv_count got %0d want 0", dv_cnt - n0); end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = dv_cnt;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    cells(1);
    checks++; if (dv_cnt - n0 !== 2) begin errors++; $display("FAIL b2b_dv_count got %0d want 2", dv_cnt - n0); end
    checks++; if (prev_byte !== 8'h00) begin errors++; $display("FAIL b2b_byte0 got %h want 00", prev_byte); end
    checks++; if (last_byte !== 8'hFF) begin errors++; $display("FAIL b2b_byte1 got %h want ff", last_byte); end
    checks++; if (prev_perr !== 1'b0) begin errors++; $display("FAIL b2b_perr0 got %b want 0", prev_perr); end
    checks++; if (last_perr !== 1'b0) begin errors++; $display("FAIL b2b_perr1 got %b want 0", last_perr); end
  endtask

  task automatic test_reset_mid();
    int n0;
    n0 = dv_cnt;
    rx = 1'b0;
    cells(1);
    rx = 1'b1; cells(1);
    rx = 1'b0; cells(1);
    rx = 1'b1; cells(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL midrst_byte got %h want 00", rx_byte); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL midrst_active got %b want 0", active); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL midrst_perr got %b want 0", perr); end
    rx = 1'b1;
    cells(12);
    checks++; if (dv_cnt - n0 !== 0) begin errors++; $display("FAIL midrst_dv_count got %0d want 0", dv_cnt - n0); end
    send_frame(8'h3C, 1'b0, 1'b1);
    cells(1);
    checks++; if (dv_cnt - n0 !== 1) begin errors++; $display("FAIL f3c_dv_count got %0d want 1", dv_cnt - n0); end
    checks++; if (last_byte !== 8'h3C) begin errors++; $display("FAIL f3c_byte got %h want 3c", last_byte); end
    checks++; if (last_perr !== 1'b0) begin errors++; $display("FAIL f3c_perr got %b want 0", last_perr); end
  endtask

`ifdef UART_RX_FRAME_ERR_EN
  task automatic test_frame_err();
    int n0;
    n0 = dv_cnt;
    send_frame(8'hC3, 1'b0, 1'b0);
    cells(2);
    checks++; if (dv_cnt - n0 !== 1) begin errors++; $display("FAIL ferr_dv_count got %0d want 1", dv_cnt - n0); end
    checks++; if (last_byte !== 8'hC3) begin errors++; $display("FAIL ferr_byte got %h want c3", last_byte); end
    checks++; if (last_ferr !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b want 1", last_ferr); end
    rx = 1'b1;
    cells(12);
    checks++; if (dv_cnt - n0 !== 1) begin errors++; $display("FAIL break_dv_count got %0d want 1", dv_cnt - n0); end
    send_frame(8'h55, 1'b0, 1'b1);
    cells(1);
    checks++; if (dv_cnt - n0 !== 2) begin errors++; $display("FAIL f55_dv_count got %0d want 2", dv_cnt - n0); end
    checks++; if (last_byte !== 8'h55) begin errors++; $display("FAIL f55_byte got %h want 55", last_byte); end
    checks++; if (last_ferr !== 1'b0) begin errors++; $display("FAIL f55_ferr got %b want 0", last_ferr); end
  endtask
`else
  task automatic test_frame_err();
    int n0;
    n0 = dv_cnt;
    send_frame(8'hC3, 1'b0, 1'b0);
    rx = 1'b1;
    cells(3);
    checks++; if (dv_cnt - n0 !== 1) begin errors++; $display("FAIL badstop_dv_count got %0d want 1", dv_cnt - n0); end
    checks++; if (last_byte !== 8'hC3) begin errors++; $display("FAIL badstop_byte got %h want c3", last_byte); end
    send_frame(8'h55, 1'b0, 1'b1);
    cells(1);
    checks++; if (dv_cnt - n0 !== 2) begin errors++; $display("FAIL f55_dv_count got %0d want 2", dv_cnt - n0); end
    checks++; if (last_byte !== 8'h55) begin errors++; $display("FAIL f55_byte got %h want 55", last_byte); end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_frame_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
